// File: rtl/piece_pose_tracker.sv
// piece_pose_tracker
//   Holds the pose (column, row, rotation) of the active falling piece and
//   turns raw keycodes into edge-detected actions with delayed auto-shift
//   and auto-repeat. Legality of every move comes from the collision
//   checker through the can_* flags; this block only enforces board bounds.
//
// Ports
//   Clk              system clock
//   reset            asynchronous active-high reset (spawn pose, key state cleared)
//   keycode[7:0]     current key: 04 left, 07 right, 1A rot CW, 14 rot CCW,
//                    16 soft drop, 06 swap, 00 none
//   state[2:0]       game FSM state: 001 gravity tick, 010 spawn
//   can_shift_left   left move legal
//   can_shift_right  right move legal
//   can_rotate_cw    CW rotation legal
//   can_rotate_ccw   CCW rotation legal
//   can_fall         one-row drop legal
//   can_swap         hold/swap legal
//   centerX[XW-1:0]  piece center column
//   centerY[YW-1:0]  piece center row
//   rot[1:0]         rotation index 0..3
//   moved            one-cycle pulse, one cycle after a non-reset pose change
module piece_pose_tracker #(
  parameter int BOARD_W     = 10,
  parameter int BOARD_H     = 24,
  parameter int XW          = 4,
  parameter int YW          = 5,
  parameter int SPAWN_X     = 5,
  parameter int SPAWN_Y     = 20,
  parameter int X_RIGHT_DEC = 1,
  parameter int DAS_DELAY   = 16,
  parameter int ARR_PERIOD  = 4,
  parameter int CW          = 8
) (
  input  logic          Clk,
  input  logic          reset,
  input  logic [7:0]    keycode,
  input  logic [2:0]    state,
  input  logic          can_shift_left,
  input  logic          can_shift_right,
  input  logic          can_rotate_cw,
  input  logic          can_rotate_ccw,
  input  logic          can_fall,
  input  logic          can_swap,
  output logic [XW-1:0] centerX,
  output logic [YW-1:0] centerY,
  output logic [1:0]    rot,
  output logic          moved
);

  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_CW    = 8'h1A;
  localparam logic [7:0] KEY_CCW   = 8'h14;
  localparam logic [7:0] KEY_DROP  = 8'h16;
  localparam logic [7:0] KEY_SWAP  = 8'h06;

  localparam logic [2:0] ST_GRAVITY = 3'b001;
  localparam logic [2:0] ST_SPAWN   = 3'b010;

  // Spawn coordinates are clamped onto the board so a mis-set parameter
  // can never place the piece out of range.
  localparam int SX_C = (SPAWN_X < BOARD_W) ? SPAWN_X : BOARD_W - 1;
  localparam int SY_C = (SPAWN_Y < BOARD_H) ? SPAWN_Y : BOARD_H - 1;

  localparam logic [XW-1:0] X_SPAWN    = XW'(SX_C);
  localparam logic [XW-1:0] X_MAX      = XW'(BOARD_W - 1);
  localparam logic [YW-1:0] Y_SPAWN    = YW'(SY_C);
  localparam logic [CW-1:0] CNT_DAS    = CW'(DAS_DELAY);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(DAS_DELAY - ARR_PERIOD);
  localparam bit            RIGHT_DEC  = (X_RIGHT_DEC != 0);

  logic [7:0]    r_prev_key;
  logic [CW-1:0] r_cnt;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [1:0]    r_rot;
  logic          r_chg;
  logic          r_moved;

  logic          w_press, w_held, w_rep_key, w_repeat, w_act;
  logic [CW-1:0] w_cnt_inc, w_cnt_next;
  logic          w_reload, w_rot_act, w_y_dn;
  logic          w_left, w_right, w_x_up, w_x_dn, w_x_inc, w_x_dec;
  logic          w_rot_cw, w_rot_ccw;
  logic [XW-1:0] w_x_next;
  logic [YW-1:0] w_y_next;
  logic [1:0]    w_rot_next;
  logic          w_chg;

  // Key action generation: a new press acts at once; a held repeatable key
  // acts when the counter would step onto DAS_DELAY, then reloads so each
  // further action lands ARR_PERIOD cycles later.
  assign w_press   = (keycode != 8'h00) && (keycode != r_prev_key);
  assign w_held    = (keycode != 8'h00) && (keycode == r_prev_key);
  assign w_rep_key = (keycode == KEY_LEFT) || (keycode == KEY_RIGHT) ||
                     (keycode == KEY_DROP);
  assign w_cnt_inc = r_cnt + CW'(1);
  assign w_repeat  = w_held && w_rep_key && (w_cnt_inc == CNT_DAS);
  assign w_act     = w_press || w_repeat;

  // Non-repeating keys let the counter park at DAS_DELAY instead of wrapping.
  always_comb begin
    w_cnt_next = '0;
    if (w_press)
      w_cnt_next = '0;
    else if (w_repeat)
      w_cnt_next = CNT_RELOAD;
    else if (w_held && (r_cnt != CNT_DAS))
      w_cnt_next = w_cnt_inc;
    else if (w_held)
      w_cnt_next = r_cnt;
  end

  // Move decode. A rotate cycle never moves Y, even with gravity pending;
  // gravity and soft drop share the single-row step.
  assign w_reload  = (state == ST_SPAWN) ||
                     (w_act && (keycode == KEY_SWAP) && can_swap);
  assign w_rot_act = w_act && ((keycode == KEY_CW) || (keycode == KEY_CCW));
  assign w_y_dn    = ((state == ST_GRAVITY) || (w_act && (keycode == KEY_DROP))) &&
                     !w_rot_act && can_fall && (r_y != '0);

  assign w_left    = w_act && (keycode == KEY_LEFT)  && can_shift_left;
  assign w_right   = w_act && (keycode == KEY_RIGHT) && can_shift_right;
  assign w_x_up    = (w_left && RIGHT_DEC) || (w_right && !RIGHT_DEC);
  assign w_x_dn    = (w_left && !RIGHT_DEC) || (w_right && RIGHT_DEC);
  assign w_x_inc   = w_x_up && (r_x < X_MAX);
  assign w_x_dec   = w_x_dn && (r_x != '0);

  assign w_rot_cw  = w_act && (keycode == KEY_CW)  && can_rotate_cw;
  assign w_rot_ccw = w_act && (keycode == KEY_CCW) && can_rotate_ccw;

  always_comb begin
    w_x_next   = r_x;
    w_y_next   = r_y;
    w_rot_next = r_rot;
    if (w_reload) begin
      w_x_next   = X_SPAWN;
      w_y_next   = Y_SPAWN;
      w_rot_next = 2'd0;
    end else begin
      if (w_y_dn)
        w_y_next = r_y - YW'(1);
      if (w_x_inc)
        w_x_next = r_x + XW'(1);
      else if (w_x_dec)
        w_x_next = r_x - XW'(1);
      if (w_rot_cw)
        w_rot_next = r_rot + 2'd1;
      else if (w_rot_ccw)
        w_rot_next = r_rot - 2'd1;
    end
  end

  assign w_chg = !w_reload &&
                 ((w_x_next != r_x) || (w_y_next != r_y) || (w_rot_next != r_rot));

  // Pose updates on the action edge; moved trails the change flag by a
  // further cycle and is forced low whenever the spawn pose is reloaded.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_prev_key <= 8'h00;
      r_cnt      <= '0;
      r_x        <= X_SPAWN;
      r_y        <= Y_SPAWN;
      r_rot      <= 2'd0;
      r_chg      <= 1'b0;
      r_moved    <= 1'b0;
    end else begin
      r_prev_key <= keycode;
      r_cnt      <= w_cnt_next;
      r_x        <= w_x_next;
      r_y        <= w_y_next;
      r_rot      <= w_rot_next;
      r_chg      <= w_chg;
      r_moved    <= w_reload ? 1'b0 : r_chg;
    end
  end

  assign centerX = r_x;
  assign centerY = r_y;
  assign rot     = r_rot;
  assign moved   = r_moved;

endmodule

// File: tb/tb_piece_pose_tracker.sv
module tb_piece_pose_tracker;

  localparam int DAS = 16;
  localparam int ARR = 4;
  localparam int SX  = 5;
  localparam int SY  = 20;

  logic       Clk;
  logic       reset;
  logic [7:0] keycode;
  logic [2:0] state;
  logic       can_shift_left, can_shift_right, can_rotate_cw, can_rotate_ccw;
  logic       can_fall, can_swap;

  logic [3:0] x0, x1;
  logic [4:0] y0, y1;
  logic [1:0] r0, r1;
  logic       m0, m1;

  // Default build: right key decrements X on a 10-column board.
  piece_pose_tracker dut0 (
    .Clk(Clk), .reset(reset), .keycode(keycode), .state(state),
    .can_shift_left(can_shift_left), .can_shift_right(can_shift_right),
    .can_rotate_cw(can_rotate_cw), .can_rotate_ccw(can_rotate_ccw),
    .can_fall(can_fall), .can_swap(can_swap),
    .centerX(x0), .centerY(y0), .rot(r0), .moved(m0)
  );

  // Alternate build: right key increments X on a 12-column board.
  piece_pose_tracker #(.X_RIGHT_DEC(0), .BOARD_W(12)) dut1 (
    .Clk(Clk), .reset(reset), .keycode(keycode), .state(state),
    .can_shift_left(can_shift_left), .can_shift_right(can_shift_right),
    .can_rotate_cw(can_rotate_cw), .can_rotate_ccw(can_rotate_ccw),
    .can_fall(can_fall), .can_swap(can_swap),
    .centerX(x1), .centerY(y1), .rot(r1), .moved(m1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: hold time of the current key, and one pose per build.
  logic [7:0] mprev;
  int         mh;
  int         mx0, my0, mr0, mx1, my1, mr1;
  bit         mc0, mm0, mc1, mm1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_pose(input string name, input int ax, input int ay, input int ar,
                          input int am, input int ex, input int ey, input int er,
                          input int em);
    n_checks++;
    if (ax != ex || ay != ey || ar != er || am != em) begin
      n_fail++;
      $display("FAIL %s: got x=%0d y=%0d rot=%0d moved=%0d expected x=%0d y=%0d rot=%0d moved=%0d at %0t",
               name, ax, ay, ar, am, ex, ey, er, em, $time);
    end
  endtask

  function automatic void model_reset();
    mprev = 8'h00; mh = 0;
    mx0 = SX; my0 = SY; mr0 = 0; mc0 = 0; mm0 = 0;
    mx1 = SX; my1 = SY; mr1 = 0; mc1 = 0; mm1 = 0;
  endfunction

  // One cycle of pose rules for a board of width bw; rdec selects whether
  // the right key decrements X.
  function automatic void upd(input int bw, input bit rdec, input bit act,
                              input logic [7:0] key, inout int x, inout int y,
                              inout int r, inout bit chg, inout bit mv);
    int ox, oy, orr;
    bit rotk, up;
    if (state == 3'b010 || (act && key == 8'h06 && can_swap)) begin
      x = SX; y = SY; r = 0; chg = 0; mv = 0;
      return;
    end
    ox = x; oy = y; orr = r;
    rotk = act && (key == 8'h1A || key == 8'h14);
    if (!rotk && (state == 3'b001 || (act && key == 8'h16)) && can_fall && y > 0)
      y = y - 1;
    if (act && ((key == 8'h04 && can_shift_left) || (key == 8'h07 && can_shift_right))) begin
      up = ((key == 8'h04) == rdec);
      if (up) begin
        if (x < bw - 1) x = x + 1;
      end else if (x > 0) begin
        x = x - 1;
      end
    end
    if (act && key == 8'h1A && can_rotate_cw)  r = (r + 1) % 4;
    if (act && key == 8'h14 && can_rotate_ccw) r = (r + 3) % 4;
    mv  = chg;
    chg = (x != ox) || (y != oy) || (r != orr);
  endfunction

  // Advance one clock, update the model from the inputs seen at the edge,
  // and compare both builds against it.
  task automatic step();
    int  h;
    bit  act, rep;
    if (!reset) begin
      if (keycode != 8'h00 && keycode != mprev) h = 1;
      else if (keycode != 8'h00)                h = mh + 1;
      else                                      h = 0;
      rep = (keycode == 8'h04 || keycode == 8'h07 || keycode == 8'h16);
      act = (h == 1) || (rep && h > DAS && ((h - 1 - DAS) % ARR) == 0);
      upd(10, 1'b1, act, keycode, mx0, my0, mr0, mc0, mm0);
      upd(12, 1'b0, act, keycode, mx1, my1, mr1, mc1, mm1);
      mh = h;
      mprev = keycode;
    end
    @(posedge Clk);
    #1;
    if (reset) model_reset();
    chk_pose("model_dut0", int'(x0), int'(y0), int'(r0), int'(m0), mx0, my0, mr0, int'(mm0));
    chk_pose("model_dut1", int'(x1), int'(y1), int'(r1), int'(m1), mx1, my1, mr1, int'(mm1));
  endtask

  typedef struct {
    logic [7:0] key;
    logic [2:0] st;
    logic [5:0] can;   // {left, right, cw, ccw, fall, swap}
    int         ex, ey, er, em;
  } vec_t;

  vec_t tbl[20];

  task automatic set_can(input logic [5:0] c);
    {can_shift_left, can_shift_right, can_rotate_cw, can_rotate_ccw, can_fall, can_swap} = c;
  endtask

  initial begin
    logic [7:0] keys[7];
    keys[0] = 8'h00; keys[1] = 8'h04; keys[2] = 8'h07; keys[3] = 8'h1A;
    keys[4] = 8'h14; keys[5] = 8'h16; keys[6] = 8'h06;

    tbl[0]  = '{8'h04, 3'b000, 6'h3F, 6, 20, 0, 0};
    tbl[1]  = '{8'h00, 3'b000, 6'h3F, 6, 20, 0, 1};
    tbl[2]  = '{8'h07, 3'b000, 6'h3F, 5, 20, 0, 0};
    tbl[3]  = '{8'h00, 3'b000, 6'h3F, 5, 20, 0, 1};
    tbl[4]  = '{8'h1A, 3'b000, 6'h3F, 5, 20, 1, 0};
    tbl[5]  = '{8'h14, 3'b000, 6'h3F, 5, 20, 0, 1};
    tbl[6]  = '{8'h14, 3'b000, 6'h3F, 5, 20, 0, 1};
    tbl[7]  = '{8'h00, 3'b000, 6'h3F, 5, 20, 0, 0};
    tbl[8]  = '{8'h14, 3'b000, 6'h3F, 5, 20, 3, 0};
    tbl[9]  = '{8'h16, 3'b001, 6'h3F, 5, 19, 3, 1};
    tbl[10] = '{8'h00, 3'b001, 6'h3D, 5, 19, 3, 1};
    tbl[11] = '{8'h04, 3'b000, 6'h1F, 5, 19, 3, 0};
    tbl[12] = '{8'h00, 3'b001, 6'h3F, 5, 18, 3, 0};
    tbl[13] = '{8'h06, 3'b000, 6'h3E, 5, 18, 3, 1};
    tbl[14] = '{8'h00, 3'b000, 6'h3F, 5, 18, 3, 0};
    tbl[15] = '{8'h04, 3'b000, 6'h3F, 6, 18, 3, 0};
    tbl[16] = '{8'h06, 3'b000, 6'h3F, 5, 20, 0, 0};
    tbl[17] = '{8'h00, 3'b000, 6'h3F, 5, 20, 0, 0};
    tbl[18] = '{8'h1A, 3'b000, 6'h37, 5, 20, 0, 0};
    tbl[19] = '{8'h00, 3'b010, 6'h3F, 5, 20, 0, 0};

    reset = 1'b1; keycode = 8'h00; state = 3'b000; set_can(6'h3F);
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    chk_pose("reset_state", int'(x0), int'(y0), int'(r0), int'(m0), 5, 20, 0, 0);
    reset = 1'b0;

    // Directed vector table from the reset pose.
    for (int i = 0; i < 20; i++) begin
      keycode = tbl[i].key; state = tbl[i].st; set_can(tbl[i].can);
      step();
      chk_pose($sformatf("table_row%0d", i), int'(x0), int'(y0), int'(r0), int'(m0),
               tbl[i].ex, tbl[i].ey, tbl[i].er, tbl[i].em);
    end
    keycode = 8'h00; state = 3'b000; set_can(6'h3F);
    step();

    // Held right key: DAS then ARR, saturating at both board edges.
    for (int k = 1; k <= 38; k++) begin
      keycode = 8'h07;
      step();
      if (k == 1)  begin chk("das_first0", int'(x0), 4); chk("das_first1", int'(x1), 6); end
      if (k == 16) chk("das_wait0", int'(x0), 4);
      if (k == 17) begin chk("das_fire0", int'(x0), 3); chk("das_fire1", int'(x1), 7); end
      if (k == 29) begin chk("arr_edge0", int'(x0), 0); chk("arr_29_1", int'(x1), 10); end
      if (k == 30) chk("arr_moved0", int'(m0), 1);
      if (k == 33) begin chk("sat_low0", int'(x0), 0); chk("sat_hi1", int'(x1), 11); end
      if (k == 34) begin chk("blocked_moved0", int'(m0), 0); chk("last_moved1", int'(m1), 1); end
      if (k == 37) chk("sat_hold1", int'(x1), 11);
      if (k == 38) chk("blocked_moved1", int'(m1), 0);
    end
    keycode = 8'h00;
    step();

    // Asynchronous reset between clock edges while a key is held.
    keycode = 8'h04;
    repeat (3) step();
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    chk_pose("async_reset", int'(x0), int'(y0), int'(r0), int'(m0), 5, 20, 0, 0);
    keycode = 8'h00;
    repeat (2) step();
    reset = 1'b0;
    repeat (2) step();
    chk("post_reset_idle", int'(x0), 5);
    keycode = 8'h04;
    step();
    chk("post_reset_press", int'(x0), 6);
    keycode = 8'h00;
    step();

    // Rotate acts once per press, never on repeat.
    keycode = 8'h1A;
    for (int k = 1; k <= 40; k++) step();
    chk("rot_hold", int'(r0), 1);
    keycode = 8'h00; step();
    keycode = 8'h14; step();
    chk("rot_ccw1", int'(r0), 0);
    keycode = 8'h00; step();
    keycode = 8'h14; step();
    chk("rot_ccw_wrap", int'(r0), 3);
    keycode = 8'h00; step();

    // Gravity and soft drop in one cycle move one row; floor holds at 0.
    state = 3'b001; keycode = 8'h16;
    step();
    chk("grav_plus_drop", int'(y0), 19);
    keycode = 8'h00;
    repeat (25) step();
    chk("grav_floor", int'(y0), 0);
    state = 3'b000; keycode = 8'h16;
    repeat (20) step();
    chk("drop_floor", int'(y0), 0);
    chk("drop_floor_moved", int'(m0), 0);
    keycode = 8'h00; step();

    // Swap legality and spawn overriding a held repeat.
    for (int k = 0; k < 4; k++) begin
      keycode = 8'h07; step();
      keycode = 8'h00; step();
    end
    chk("x_at_two", int'(x0), 2);
    can_swap = 1'b0; keycode = 8'h06;
    step();
    chk_pose("swap_blocked", int'(x0), int'(y0), int'(r0), int'(m0), 2, 0, 3, 0);
    keycode = 8'h00; step();
    can_swap = 1'b1; keycode = 8'h06;
    step();
    chk_pose("swap_ok", int'(x0), int'(y0), int'(r0), int'(m0), 5, 20, 0, 0);
    keycode = 8'h00; step();
    for (int k = 1; k <= 21; k++) begin
      keycode = 8'h04;
      state = (k == 21) ? 3'b010 : 3'b000;
      step();
      if (k == 17) chk("spawn_pre", int'(x0), 7);
    end
    chk_pose("spawn_wins", int'(x0), int'(y0), int'(r0), int'(m0), 5, 20, 0, 0);
    state = 3'b000; keycode = 8'h00; step();

    // Randomised run against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(7) == 0) keycode = keys[$urandom_range(6)];
      case ($urandom_range(63))
        0:               state = 3'b010;
        1, 2, 3, 4, 5,
        6, 7, 8:         state = 3'b001;
        9:               state = 3'($urandom_range(7));
        default:         state = 3'b000;
      endcase
      set_can({($urandom_range(3) != 0), ($urandom_range(3) != 0), ($urandom_range(3) != 0),
               ($urandom_range(3) != 0), ($urandom_range(3) != 0), ($urandom_range(3) != 0)});
      if (reset && $urandom_range(1) == 0) reset = 1'b0;
      if (!reset && $urandom_range(499) == 0) begin
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk_pose("rand_async_reset", int'(x0), int'(y0), int'(r0), int'(m0), 5, 20, 0, 0);
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
